rw_bit_host: RTL and testbench

Host-side driver for a ReWire-generated single-bit reactive device: the `__in0`/`__out0`/`__continue` port set of a compiled `top_level`. It takes host words on a valid/ready stream and serializes them LSB-first into the device's 1-bit input, one bit per device step. It deserializes the device's 1-bit output from those same steps back into words, and detects device termination through `__continue`. It sits between a host or bus FIFO and the compiled device, which steps on every `clk` edge and cannot be stalled.

---
 rtl/rw_bit_host.sv | 164 ++++++++++++++++
 tb/tb_rw_bit_host.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rw_bit_host.sv
// Host-side bit-serial driver for a single-bit reactive device: serializes host
// words LSB-first onto dev_in, rebuilds result words from dev_out, tracks termination.
module rw_bit_host #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             dev_in,
  input  logic             dev_out,
  input  logic             dev_continue,
  output logic             done,
  output logic             overflow,
  output logic             partial
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  // Only the upper WIDTH-1 received bits need holding; the newest comes live from dev_out.
  logic [WIDTH-2:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             overflow_q, overflow_d;
  logic             partial_q, partial_d;

  logic             active_s;
  logic             hs_s;
  logic             load_s;
  logic [WIDTH-1:0] word_s;

  assign active_s = (state_q == RUN) && (tx_cnt_q != CNT_ZERO);
  assign s_ready  = (state_q == RUN) && ((tx_cnt_q == CNT_ZERO) || (tx_cnt_q == CNT_ONE));
  assign hs_s     = s_valid && s_ready;
  assign dev_in   = active_s ? tx_sr_q[0] : IDLE_BIT;
  assign word_s   = {dev_out, rx_sr_q};

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign done     = (state_q == DONE);
  assign overflow = overflow_q;
  assign partial  = partial_q;

  // Next-state logic for the FSM, both shift paths and the result register.
  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    rx_sr_d    = rx_sr_q;
    rx_cnt_d   = rx_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    overflow_d = overflow_q;
    partial_d  = partial_q;
    load_s     = 1'b0;

    case (state_q)
      RUN: begin
        // A handshake on the last bit's step reloads while that bit is still captured.
        if (hs_s) begin
          tx_sr_d  = s_data;
          tx_cnt_d = CNT_FULL;
        end else if (active_s) begin
          tx_sr_d  = tx_sr_q >> 1;
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end else begin
          tx_cnt_d = tx_cnt_q;
        end

        if (active_s) begin
          rx_sr_d = word_s[WIDTH-1:1];
          if (rx_cnt_q == CNT_LAST) begin
            rx_cnt_d = CNT_ZERO;
            load_s   = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q;
        end

        if (!dev_continue) begin
          state_d  = DONE;
          tx_cnt_d = CNT_ZERO;
          if (rx_cnt_d != CNT_ZERO) begin
            partial_d = 1'b1;
          end else begin
            partial_d = partial_q;
          end
          rx_cnt_d = CNT_ZERO;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d  = DONE;
        tx_cnt_d = CNT_ZERO;
        rx_cnt_d = CNT_ZERO;
      end
      default: begin
        state_d  = DONE;
        tx_cnt_d = CNT_ZERO;
        rx_cnt_d = CNT_ZERO;
      end
    endcase

    if (load_s) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = word_s;
        m_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State register; asynchronous reset abandons any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      tx_sr_q    <= {WIDTH{1'b0}};
      tx_cnt_q   <= CNT_ZERO;
      rx_sr_q    <= {(WIDTH-1){1'b0}};
      rx_cnt_q   <= CNT_ZERO;
      m_data_q   <= {WIDTH{1'b0}};
      m_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
      partial_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      rx_cnt_q   <= rx_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      overflow_q <= overflow_d;
      partial_q  <= partial_d;
    end
  end

endmodule

// File: tb/tb_rw_bit_host.sv
// Bench for rw_bit_host: bit-queue reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and a randomized soak.
module tb_rw_bit_host;
  localparam int   W    = 8;
  localparam logic IDLE = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [W-1:0] m_data;
  logic         dev_in;
  logic         dev_out;
  logic         dev_continue = 1'b1;
  logic         done, overflow, partial;
  logic         rnd_bit = 1'b0;
  int           mode = 0;   // device behaviour: 0 loopback, 1 inverter, 2 random bits

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [W-1:0] got[$];

  always #5 clk = ~clk;

  assign dev_out = (mode == 0) ? dev_in : ((mode == 1) ? ~dev_in : rnd_bit);

  rw_bit_host #(.WIDTH(W), .IDLE_BIT(IDLE)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .dev_in(dev_in), .dev_out(dev_out), .dev_continue(dev_continue),
    .done(done), .overflow(overflow), .partial(partial)
  );

  // Reference model: queue of bits still to be driven, list of bits received.
  logic         mq_tx[$];
  logic         mq_rx[$];
  logic         e_mvalid = 1'b0;
  logic [W-1:0] e_mdata  = '0;
  logic         e_done = 1'b0, e_ovf = 1'b0, e_part = 1'b0;

  function automatic logic devf(logic b);
    return (mode == 0) ? b : ((mode == 1) ? ~b : rnd_bit);
  endfunction

  function automatic logic e_sready();
    return !e_done && (mq_tx.size() <= 1);
  endfunction

  function automatic logic e_devin();
    return (!e_done && mq_tx.size() != 0) ? mq_tx[0] : IDLE;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update at every clock edge, or immediately on reset.
  initial begin : model
    logic hs, loaded;
    logic [W-1:0] word;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq_tx.delete(); mq_rx.delete();
        e_mvalid = 1'b0; e_mdata = '0; e_done = 1'b0; e_ovf = 1'b0; e_part = 1'b0;
      end else begin
        hs = s_valid && e_sready();
        loaded = 1'b0;
        word = '0;
        if (!e_done) begin
          if (mq_tx.size() != 0) begin
            mq_rx.push_back(devf(mq_tx[0]));
            void'(mq_tx.pop_front());
            if (mq_rx.size() == W) begin
              for (int i = 0; i < W; i++) word = word | (W'(mq_rx[i]) << i);
              loaded = 1'b1;
              mq_rx.delete();
            end
          end
          if (hs) for (int i = 0; i < W; i++) mq_tx.push_back(s_data[i]);
          if (!dev_continue) begin
            e_done = 1'b1;
            if (mq_rx.size() != 0) e_part = 1'b1;
            mq_rx.delete();
            mq_tx.delete();
          end
        end
        if (loaded) begin
          if (!e_mvalid || m_ready) begin
            e_mdata = word;
            e_mvalid = 1'b1;
          end else begin
            e_ovf = 1'b1;
          end
        end else if (e_mvalid && m_ready) begin
          e_mvalid = 1'b0;
        end
      end
    end
  end

  // Compare process: every output against the model, mid-cycle.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("s_ready",  s_ready,  e_sready());
        chk("dev_in",   dev_in,   e_devin());
        chk("m_valid",  m_valid,  e_mvalid);
        chk("m_data",   m_data,   e_mdata);
        chk("done",     done,     e_done);
        chk("overflow", overflow, e_ovf);
        chk("partial",  partial,  e_part);
      end
    end
  end

  // Collect delivered result words.
  initial begin : collector
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) got.push_back(m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    chk("wait_ready", s_ready, 1'b1);
  endtask

  initial begin : stim
    logic [W-1:0] seq;
    logic [W-1:0] words[3];
    int hsc[3];

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    #2;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data",  m_data,  8'h00);
    chk("rst_dev_in",  dev_in,  IDLE);
    chk("rst_done",    done,    1'b0);
    chk("rst_ovf",     overflow, 1'b0);
    chk("rst_partial", partial, 1'b0);
    rst = 1'b0;
    tick();

    // Loopback 0xA5
    got.delete();
    mode = 0;
    s_data = 8'hA5;
    s_valid = 1'b1;
    wait_ready();
    tick();
    s_valid = 1'b0;
    seq = 8'b1010_0101;   // dev_in order 1,0,1,0,0,1,0,1 read LSB-first
    for (int k = 0; k < W; k++) begin
      chk("lb_dev_in", dev_in, seq[k]);
      chk("lb_mvalid_early", m_valid, 1'b0);
      tick();
    end
    chk("lb_mvalid", m_valid, 1'b1);
    chk("lb_mdata", m_data, 8'hA5);
    tick();

    // Back-to-back words with s_valid held
    got.delete();
    words[0] = 8'h01; words[1] = 8'hFF; words[2] = 8'h3C;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = words[i];
      wait_ready();
      hsc[i] = cyc;
      tick();
    end
    s_valid = 1'b0;
    repeat (12) tick();
    chk("b2b_gap01", 8'(hsc[1] - hsc[0]), 8'd8);
    chk("b2b_gap12", 8'(hsc[2] - hsc[1]), 8'd8);
    chk("b2b_count", 8'(got.size()), 8'd3);
    if (got.size() == 3) for (int i = 0; i < 3; i++) chk("b2b_word", got[i], words[i]);

    // Overflow with consumer stalled
    got.delete();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h5A;
    wait_ready();
    tick();
    s_data = 8'hC3;
    wait_ready();
    tick();
    s_valid = 1'b0;
    repeat (7) tick();
    chk("ovf_before", overflow, 1'b0);
    tick();
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_mvalid", m_valid, 1'b1);
    chk("ovf_mdata", m_data, 8'h5A);
    repeat (3) tick();
    chk("ovf_none_out", 8'(got.size()), 8'd0);
    m_ready = 1'b1;
    tick();
    chk("ovf_drained", m_valid, 1'b0);
    chk("ovf_got_count", 8'(got.size()), 8'd1);
    if (got.size() == 1) chk("ovf_got_word", got[0], 8'h5A);

    // Termination mid-word on the 3rd active step
    got.delete();
    mode = 1;
    s_data = 8'h0F;
    s_valid = 1'b1;
    wait_ready();
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    dev_continue = 1'b0;
    tick();
    dev_continue = 1'b1;
    chk("term_done", done, 1'b1);
    chk("term_partial", partial, 1'b1);
    chk("term_mvalid", m_valid, 1'b0);
    chk("term_s_ready", s_ready, 1'b0);
    chk("term_dev_in", dev_in, IDLE);
    s_valid = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0;
    chk("term_s_ready_hold", s_ready, 1'b0);
    chk("term_dev_in_hold", dev_in, IDLE);
    chk("term_no_result", 8'(got.size()), 8'd0);

    // Async reset during bit 4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    mode = 0;
    s_data = 8'h96;
    s_valid = 1'b1;
    wait_ready();
    tick();
    s_valid = 1'b0;
    repeat (4) tick();
    chk("ar_bit4", dev_in, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_s_ready", s_ready, 1'b1);
    chk("ar_dev_in", dev_in, IDLE);
    chk("ar_m_valid", m_valid, 1'b0);
    chk("ar_m_data", m_data, 8'h00);
    chk("ar_done", done, 1'b0);
    chk("ar_ovf", overflow, 1'b0);
    chk("ar_partial", partial, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    got.delete();
    s_data = 8'h3C;
    s_valid = 1'b1;
    wait_ready();
    tick();
    s_valid = 1'b0;
    repeat (12) tick();
    chk("ar_fresh_count", 8'(got.size()), 8'd1);
    if (got.size() == 1) chk("ar_fresh_word", got[0], 8'h3C);

    // Termination while idle
    dev_continue = 1'b0;
    tick();
    dev_continue = 1'b1;
    chk("idle_done", done, 1'b1);
    chk("idle_partial", partial, 1'b0);
    chk("idle_ovf", overflow, 1'b0);

    // Randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int n = 0; n < 400; n++) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data = W'($urandom);
        m_ready = ($urandom_range(0, (ep % 3) + 1) != 0);
        mode = int'($urandom_range(0, 2));
        rnd_bit = 1'($urandom);
        dev_continue = ($urandom_range(0, 299) != 0);
        tick();
      end
      dev_continue = 1'b1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
